// File: rtl/conv1_psum_drain.sv
// Output drain for the conv1 PE column: bias, optional ReLU, rounding shift and int8
// saturation, then packs four bytes per word into a small FIFO for the ofmap writer.
module conv1_psum_drain #(
  parameter int PSUM_W     = 20,
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  frame_len,
  input  logic [PSUM_W-1:0] bias,
  input  logic [3:0]        shift,
  input  logic              relu_en,
  input  logic              psum_vld,
  input  logic [PSUM_W-1:0] psum_in,
  output logic              psum_rdy,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic [31:0]       out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic signed [PSUM_W+1:0] RND_ONE = {{(PSUM_W+1){1'b0}}, 1'b1};
  localparam logic signed [PSUM_W+1:0] SAT_HI  = 127;
  localparam logic signed [PSUM_W+1:0] SAT_LO  = -128;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t                    state;
  logic [LEN_W-1:0]          len_r;
  logic [PSUM_W-1:0]         bias_r;
  logic [3:0]                shift_r;
  logic                      relu_r;
  logic [LEN_W-1:0]          acc_cnt;
  logic                      s1_vld, s1_last, s2_vld, s2_last;
  logic signed [PSUM_W:0]    s1;
  logic [7:0]                s2_byte;
  logic [1:0]                byte_idx;
  logic [23:0]               lanes;
  logic [32:0]               mem [FIFO_DEPTH];
  logic [PTR_W-1:0]          wr_ptr, rd_ptr;
  logic [CNT_W-1:0]          count;
  logic                      accept, pop, push, push_full, flush_push, pipe_empty, flush_done;
  logic [31:0]               push_word;
  logic                      push_last;

  function automatic logic [7:0] post_scale(input logic signed [PSUM_W:0] s,
                                            input logic [3:0] sh, input logic relu);
    logic signed [PSUM_W+1:0] ext;
    logic signed [PSUM_W+1:0] r;
    ext = {s[PSUM_W], s};
    r = (sh != 4'd0) ? ((ext + (RND_ONE <<< (sh - 4'd1))) >>> sh) : ext;
    if (relu && r[PSUM_W+1]) r = '0;
    if (r > SAT_HI)      return 8'h7F;
    else if (r < SAT_LO) return 8'h80;
    else                 return r[7:0];
  endfunction

  assign psum_rdy   = (state == RUN) && (count < CNT_W'(FIFO_DEPTH - 1));
  assign accept     = psum_vld && psum_rdy;
  assign out_vld    = (count != '0);
  assign pop        = out_vld && out_rdy;
  assign out_data   = mem[rd_ptr][31:0];
  assign out_last   = mem[rd_ptr][32];
  assign pipe_empty = !s1_vld && !s2_vld;
  assign push_full  = s2_vld && (byte_idx == 2'd3);
  assign flush_push = (state == FLUSH) && pipe_empty && (byte_idx != 2'd0)
                      && (count != CNT_W'(FIFO_DEPTH));
  assign push       = push_full || flush_push;
  assign flush_done = pipe_empty && (byte_idx == 2'd0)
                      && ((count == '0) || ((count == CNT_W'(1)) && pop));

  // Word to push: a completed word, or the partial word zero-padded above byte_idx.
  always_comb begin
    push_word = 32'h0;
    push_last = 1'b1;
    if (push_full) begin
      push_word = {s2_byte, lanes};
      push_last = s2_last;
    end else begin
      case (byte_idx)
        2'd1:    push_word = {24'h0, lanes[7:0]};
        2'd2:    push_word = {16'h0, lanes[15:0]};
        2'd3:    push_word = {8'h0, lanes};
        default: push_word = 32'h0;
      endcase
    end
  end

  // Frame control FSM with registered busy/done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      len_r   <= '0;
      bias_r  <= '0;
      shift_r <= '0;
      relu_r  <= 1'b0;
      acc_cnt <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            len_r   <= frame_len;
            bias_r  <= bias;
            shift_r <= shift;
            relu_r  <= relu_en;
            acc_cnt <= '0;
            busy    <= 1'b1;
            if (frame_len == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (accept) begin
            acc_cnt <= acc_cnt + LEN_W'(1);
            if (acc_cnt == len_r - LEN_W'(1)) state <= FLUSH;
          end
        end
        FLUSH: begin
          if (flush_done) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // Two-stage arithmetic pipeline; the last flag rides along with its psum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld  <= 1'b0;
      s1      <= '0;
      s1_last <= 1'b0;
      s2_vld  <= 1'b0;
      s2_byte <= '0;
      s2_last <= 1'b0;
    end else begin
      s1_vld <= accept;
      if (accept) begin
        s1      <= $signed({psum_in[PSUM_W-1], psum_in}) + $signed({bias_r[PSUM_W-1], bias_r});
        s1_last <= (acc_cnt == len_r - LEN_W'(1));
      end
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_byte <= post_scale(s1, shift_r, relu_r);
        s2_last <= s1_last;
      end
    end
  end

  // Byte packing and output word FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_idx <= '0;
      lanes    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (s2_vld) begin
        byte_idx <= byte_idx + 2'd1;
        case (byte_idx)
          2'd0:    lanes[7:0]   <= s2_byte;
          2'd1:    lanes[15:8]  <= s2_byte;
          2'd2:    lanes[23:16] <= s2_byte;
          default: ;
        endcase
      end else if (flush_push) begin
        byte_idx <= '0;
      end
      if (push) begin
        mem[wr_ptr] <= {push_last, push_word};
        wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv1_psum_drain.sv
// Self-checking bench for conv1_psum_drain: vector table of frames, scoreboard of
// expected words, plus sequences for backpressure, empty frame and mid-frame events.
module tb_conv1_psum_drain;
  logic        clk = 1'b0, rst = 1'b0, start = 1'b0, relu_en = 1'b0;
  logic [15:0] frame_len = '0;
  logic [19:0] bias = '0, psum_in = '0;
  logic [3:0]  shift = '0;
  logic        psum_vld = 1'b0, psum_rdy, out_vld, out_rdy = 1'b0, out_last, busy, done;
  logic [31:0] out_data;

  conv1_psum_drain #(.PSUM_W(20), .FIFO_DEPTH(4), .LEN_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .frame_len(frame_len), .bias(bias),
    .shift(shift), .relu_en(relu_en), .psum_vld(psum_vld), .psum_in(psum_in),
    .psum_rdy(psum_rdy), .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0]       len;
    logic [19:0]       bias;
    logic [3:0]        shift;
    logic              relu;
    logic [7:0][19:0]  psums;
    logic [31:0]       w0;
    logic [31:0]       w1;
    logic [1:0]        nw;
  } vec_t;
  typedef struct packed { logic [31:0] data; logic last; } exp_t;

  vec_t vecs[7];
  exp_t sb[$];
  int   tests = 0, fails = 0, cyc = 0, rdy_mode = 0;
  int   done_seen = 0, done_cyc = 0, last_pop_cyc = 0;
  bit   hold_pend = 1'b0;
  logic [31:0] hold_data;
  logic hold_last;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_rdy = 1'b0;
      1:       out_rdy = 1'b1;
      default: out_rdy = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Output monitor: scoreboard pops, stability under stall, done timestamps.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        tests++;
        if (!out_vld || out_data !== hold_data || out_last !== hold_last) begin
          fails++;
          $display("FAIL hold_stable got vld=%0b %h/%0b required %h/%0b", out_vld, out_data, out_last, hold_data, hold_last);
        end
      end
      hold_pend = out_vld && !out_rdy;
      hold_data = out_data;
      hold_last = out_last;
      if (out_vld && out_rdy) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_word got %h last=%0b required none", out_data, out_last);
        end else begin
          e = sb.pop_front();
          if (out_data !== e.data || out_last !== e.last) begin
            fails++;
            $display("FAIL word got %h last=%0b required %h last=%0b", out_data, out_last, e.data, e.last);
          end
        end
        last_pop_cyc = cyc;
      end
      if (done) begin
        done_seen++;
        done_cyc = cyc;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    tests++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s got %h required %h", name, got, req);
    end
  endtask

  function automatic logic [7:0][19:0] pk(input int a0, a1, a2, a3, a4, a5, a6, a7);
    logic [7:0][19:0] r;
    r[0] = a0[19:0]; r[1] = a1[19:0]; r[2] = a2[19:0]; r[3] = a3[19:0];
    r[4] = a4[19:0]; r[5] = a5[19:0]; r[6] = a6[19:0]; r[7] = a7[19:0];
    return r;
  endfunction

  function automatic vec_t mkv(input int len, input int b, input int sh, input bit rl,
                               input logic [7:0][19:0] p, input logic [31:0] w0,
                               input logic [31:0] w1, input int nw);
    vec_t v;
    v.len = len[15:0]; v.bias = b[19:0]; v.shift = sh[3:0]; v.relu = rl;
    v.psums = p; v.w0 = w0; v.w1 = w1; v.nw = nw[1:0];
    return v;
  endfunction

  task automatic check_outputs_zero(input string name);
    check({name, "_psum_rdy"}, {31'h0, psum_rdy}, 32'h0);
    check({name, "_out_vld"},  {31'h0, out_vld},  32'h0);
    check({name, "_out_data"}, out_data, 32'h0);
    check({name, "_out_last"}, {31'h0, out_last}, 32'h0);
    check({name, "_busy"},     {31'h0, busy},     32'h0);
    check({name, "_done"},     {31'h0, done},     32'h0);
  endtask

  task automatic start_frame(input logic [15:0] len, input logic [19:0] b,
                             input logic [3:0] sh, input logic rl);
    frame_len = len; bias = b; shift = sh; relu_en = rl;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_psum(input logic [19:0] p);
    bit acc;
    int n = 0;
    psum_in = p;
    psum_vld = 1'b1;
    do begin
      acc = psum_rdy;
      tick();
      n++;
    end while (!acc && n < 500);
    if (!acc) begin
      tests++; fails++;
      $display("FAIL psum_accept got timeout required accept of %h", p);
    end
    psum_vld = 1'b0;
    psum_in = 20'($urandom);
    if ($urandom_range(0, 3) == 0) tick();
  endtask

  task automatic wait_frame_done(input string name, input bit has_words);
    int d0 = done_seen;
    int n = 0;
    while (done_seen == d0 && n < 1000) begin
      tick();
      n++;
    end
    check({name, "_done_seen"}, done_seen - d0, 32'd1);
    if (has_words) check({name, "_done_after_pop"}, done_cyc - last_pop_cyc, 32'd1);
    check({name, "_sb_empty"}, sb.size(), 32'd0);
    tick();
    check({name, "_busy_clear"}, {31'h0, busy}, 32'h0);
  endtask

  task automatic run_vec(input string name, input vec_t v, input bit mid_start);
    for (int k = 0; k < int'(v.nw); k++)
      sb.push_back({(k == 0) ? v.w0 : v.w1, (k == int'(v.nw) - 1)});
    rdy_mode = 2;
    start_frame(v.len, v.bias, v.shift, v.relu);
    for (int i = 0; i < int'(v.len); i++) begin
      send_psum(v.psums[i]);
      if (mid_start && i == 1) start_frame(16'd1, 20'd50, 4'd3, 1'b1);
    end
    wait_frame_done(name, 1'b1);
  endtask

  initial begin
    int accepted;
    int d_r;
    bit acc;
    vecs[0] = mkv(4, 0, 0, 0, pk(1, 2, 3, -4, 0, 0, 0, 0), 32'hFC030201, 32'h0, 1);
    vecs[1] = mkv(4, 0, 0, 0, pk(1000, -1000, 127, -128, 0, 0, 0, 0), 32'h807F807F, 32'h0, 1);
    vecs[2] = mkv(4, 0, 4, 0, pk(24, -24, 7, 8, 0, 0, 0, 0), 32'h0100FF02, 32'h0, 1);
    vecs[3] = mkv(4, 0, 4, 1, pk(24, -24, 7, 8, 0, 0, 0, 0), 32'h01000002, 32'h0, 1);
    vecs[4] = mkv(2, -24, 4, 0, pk(24, 40, 0, 0, 0, 0, 0, 0), 32'h00000100, 32'h0, 1);
    vecs[5] = mkv(5, 0, 0, 0, pk(1, 2, 3, 4, 5, 0, 0, 0), 32'h04030201, 32'h00000005, 2);
    vecs[6] = mkv(3, 100, 1, 1, pk(-300, 55, 400, 0, 0, 0, 0, 0), 32'h007F4E00, 32'h0, 1);

    #2 rst = 1'b1;
    #1 check_outputs_zero("reset");
    tick(); tick();
    rst = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) run_vec($sformatf("vec%0d", i), vecs[i], (i == 5));

    // Empty frame: DONE immediately, one busy cycle, no word.
    start_frame(16'd0, 20'd0, 4'd0, 1'b0);
    check("len0_busy", {31'h0, busy}, 32'h1);
    check("len0_done", {31'h0, done}, 32'h1);
    check("len0_out_vld", {31'h0, out_vld}, 32'h0);
    tick();
    check("len0_busy_after", {31'h0, busy}, 32'h0);
    check("len0_done_after", {31'h0, done}, 32'h0);

    // Backpressure: stalled output, continuous psums.
    rdy_mode = 0;
    for (int k = 0; k < 5; k++)
      sb.push_back({8'(4 * k + 4), 8'(4 * k + 3), 8'(4 * k + 2), 8'(4 * k + 1), (k == 4)});
    start_frame(16'd20, 20'd0, 4'd0, 1'b0);
    accepted = 0;
    for (int n = 0; n < 40; n++) begin
      psum_in = 20'(accepted + 1);
      psum_vld = 1'b1;
      acc = psum_rdy;
      tick();
      if (acc) accepted++;
    end
    check("bp_accepted", accepted, 32'd14);
    check("bp_psum_rdy", {31'h0, psum_rdy}, 32'h0);
    check("bp_out_vld", {31'h0, out_vld}, 32'h1);
    rdy_mode = 1;
    for (int n = 0; n < 200 && accepted < 20; n++) begin
      psum_in = 20'(accepted + 1);
      psum_vld = 1'b1;
      acc = psum_rdy;
      tick();
      if (acc) accepted++;
    end
    psum_vld = 1'b0;
    check("bp_accepted_all", accepted, 32'd20);
    wait_frame_done("bp", 1'b1);

    // Reset after six accepts discards the frame and issues no done.
    rdy_mode = 0;
    d_r = done_seen;
    start_frame(16'd20, 20'd0, 4'd0, 1'b0);
    for (int i = 0; i < 6; i++) send_psum(20'(i + 7));
    tick(); tick(); tick();
    check("rst_pre_out_vld", {31'h0, out_vld}, 32'h1);
    rst = 1'b1;
    #1 check_outputs_zero("midrst");
    sb.delete();
    tick(); tick();
    rst = 1'b0;
    for (int n = 0; n < 10; n++) tick();
    check("midrst_no_done", done_seen, d_r);
    run_vec("post_rst", vecs[0], 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/conv1_psum_drain.md
Name: conv1_psum_drain

Overview:
- Output-side drain for the conv layer 1 PE column; the receiving end of the 20-bit signed partial-sum stream leaving the last PE.
- Accepts one psum per handshake, adds bias, applies optional ReLU and a rounding arithmetic right shift, then saturates to int8.
- Packs four int8 results into a 32-bit word and buffers words in a small FIFO.
- Delivers words to the ofmap writer over a valid/ready interface, marking the last word of a frame.

Parameters:
- PSUM_W, 20, psum width; matches the PE Psum_out width.
- FIFO_DEPTH, 4, output word FIFO depth in words; must be >= 2.
- LEN_W, 16, width of the frame length counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  single-cycle pulse that begins a frame; ignored unless the FSM is in IDLE.
- frame_len  in  LEN_W  number of psums in the frame; sampled on start.
- bias  in  PSUM_W  signed bias; sampled on start.
- shift  in  4  right-shift amount, 0..15; sampled on start.
- relu_en  in  1  clamp negatives to 0; sampled on start.
- psum_vld  in  1  psum_in is valid.
- psum_in  in  PSUM_W  signed partial sum from the PE column.
- psum_rdy  out  1  drain can accept a psum; PE column en is gated by this.
- out_vld  out  1  out_data is valid.
- out_rdy  in  1  downstream accepts the word.
- out_data  out  32  packed int8 results; the first psum goes in [7:0].
- out_last  out  1  qualifies the final word of the frame.
- busy  out  1  FSM is not in IDLE.
- done  out  1  one-cycle pulse when the frame is complete.

Behaviour:
- Reset (async, rst=1): FSM goes to IDLE; all counters, pipeline valids, FIFO pointers and the packing byte index clear. Every output resets to 0.
- FSM states:
  - IDLE: on start, latch the config and go to RUN; if frame_len==0, go to DONE instead.
  - RUN: accept psums; after the frame_len-th accept, go to FLUSH.
  - FLUSH: wait until the pipeline is empty, push any partial word zero-padded in the upper bytes, then wait for the FIFO to empty; go to DONE.
  - DONE: assert done for one cycle, return to IDLE.
- Accept condition: psum_vld && psum_rdy.
- psum_rdy = (state==RUN) && (fifo_count < FIFO_DEPTH-1). At most two bytes are in flight, so the reserved slot prevents overflow.
- Stage 1 (cycle after accept): s1 = psum_in + bias, computed at PSUM_W+1 bits signed.
- Stage 2:
  - If shift>0, r = (s1 + (1<<(shift-1))) >>> shift; if shift==0, r = s1.
  - If relu_en and r<0, r = 0.
  - Saturate r to [-128, 127].
  - Write the byte into lane byte_idx, then increment byte_idx mod 4.
- Word push: when lane 3 is written, push the word into the FIFO in the same cycle as the stage-2 write.
- Last word: the last word pushed in a frame (full or padded) carries last=1 into the FIFO.
- Latency: a psum accepted at cycle t becomes a byte at t+2. A word completed at t+2 appears on out_vld at t+3 when the FIFO is empty.
- FIFO: registered output.
  - out_vld = !empty.
  - A pop occurs on out_vld && out_rdy.
  - Push and pop in the same cycle keeps fifo_count unchanged.
  - out_data and out_last hold stable while out_vld && !out_rdy.
- DONE is entered only after the last word has been popped; done therefore follows the last pop by 1 cycle.
- Wrap-around: the FIFO pointers wrap modulo FIFO_DEPTH; the accept counter never exceeds frame_len.
- Mid-frame events: start asserted while busy has no effect. rst asserted mid-frame discards all data, and no done is issued.
- psum_in values presented while psum_rdy=0 are ignored.

Test Plan:
- Basic packing: bias=0, shift=0, relu=0, frame_len=4, psums 1,2,3,-4, out_rdy=1 -> one word 0xFC030201 with out_last=1, then a done pulse 1 cycle after the pop.
- Saturation: frame_len=4, psums 1000,-1000,127,-128 -> word 0x807F807F.
- Rounding and ReLU: shift=4, bias=0.
  - psums 24,-24,7,8 with relu=0 -> bytes 2,-1,0,1 -> word 0x0100FF02.
  - Same psums with relu=1 -> word 0x01000002.
  - bias=-24, psum 24 -> byte 0.
- Partial word: frame_len=5, psums 1..5 -> words 0x04030201 (last=0), then 0x00000005 (last=1).
- Backpressure: out_rdy=0, frame_len=20, psum_vld=1 continuously -> psum_rdy deasserts once 3 words are buffered, with no overflow. Releasing out_rdy yields all 5 words in order with only the fifth carrying last=1.
- Edge and reset cases:
  - frame_len=0 -> busy for 1 cycle, done pulse, no output word.
  - rst pulsed after 6 accepts -> all outputs 0.
  - A new start with frame_len=4 then completes normally.
  - start pulsed mid-frame is ignored.
